// File: rtl/lab084_pkg.sv
// lab084_pkg: definitions shared by the lab084 input-conditioning stage and
// the downstream two-bit state machine.
//   - state_e        : encodings of the downstream machine states
//   - *_DEF          : default debounce / dwell constants
//   - cnt_width()    : counter width helper that never returns less than 1
package lab084_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10,
    ST_CLR  = 2'b11
  } state_e;

  localparam int unsigned DEB_CYCLES_DEF = 32'd4;
  localparam int unsigned DWELL_DEF      = 32'd8;

  // A counter that must reach n-1 needs $clog2(n) bits; n==1 would give 0.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/lab084_debounce.sv
// lab084_debounce: two-flop synchronizer followed by a debounce counter.
// Ports:
//   clock   in  : rising-edge clock
//   reset_n in  : synchronous active-low reset
//   sw_in   in  : raw asynchronous switch level
//   X       out : debounced level, registered; changes only after the
//                 synchronized level has differed from it for DEB_CYCLES
//                 consecutive edges
module lab084_debounce
  import lab084_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sw_in,
  output logic X
);

  localparam int unsigned    DW       = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 32'd1);

  if (DEB_CYCLES < 32'd1) begin : g_bad_deb
    $error("lab084_debounce: DEB_CYCLES must be >= 1");
  end

  logic          s1_q;
  logic          s2_q;
  logic          x_q;
  logic          x_d;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  // Debounce next-state: any agreement of s2 with X restarts the count.
  always_comb begin
    x_d   = x_q;
    cnt_d = cnt_q;
    if (s2_q == x_q) begin
      cnt_d = DW'(0);
    end else if (cnt_q == DEB_LAST) begin
      x_d   = s2_q;
      cnt_d = DW'(0);
    end else begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  // Synchronizer chain and debounce state registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      x_q   <= 1'b0;
      cnt_q <= DW'(0);
    end else begin
      s1_q  <= sw_in;
      s2_q  <= s1_q;
      x_q   <= x_d;
      cnt_q <= cnt_d;
    end
  end

  assign X = x_q;

endmodule

// File: rtl/lab084_xt_gen.sv
// lab084_xt_gen: produces the X and T inputs of the lab084 state machine.
// Ports:
//   clock   in  : rising-edge clock
//   reset_n in  : synchronous active-low reset
//   sw_in   in  : raw asynchronous switch level
//   Q1, Q0  in  : downstream state fed back (ST_WAIT = 01 arms the timer)
//   X       out : debounced switch level, registered
//   T       out : one-cycle pulse after DWELL cycles spent in ST_WAIT,
//                 registered; repeats every DWELL cycles while Q stays 01
module lab084_xt_gen
  import lab084_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned DWELL      = DWELL_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sw_in,
  input  logic Q1,
  input  logic Q0,
  output logic X,
  output logic T
);

  localparam int unsigned   TW       = cnt_width(DWELL);
  localparam logic [TW-1:0] TMR_LAST = TW'(DWELL - 32'd1);

  if (DWELL < 32'd2) begin : g_bad_dwell
    $error("lab084_xt_gen: DWELL must be >= 2");
  end

  logic          in_wait_s;
  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;
  logic          t_q;
  logic          t_d;

  lab084_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .reset_n(reset_n),
    .sw_in  (sw_in),
    .X      (X)
  );

  assign in_wait_s = ({Q1, Q0} == ST_WAIT);

  // Dwell timer next-state: wraps to 0 on the pulse so a held 01 re-arms.
  always_comb begin
    tmr_d = tmr_q;
    t_d   = 1'b0;
    if (!in_wait_s) begin
      tmr_d = TW'(0);
      t_d   = 1'b0;
    end else if (tmr_q == TMR_LAST) begin
      tmr_d = TW'(0);
      t_d   = 1'b1;
    end else begin
      tmr_d = tmr_q + TW'(1);
      t_d   = 1'b0;
    end
  end

  // Dwell timer and pulse registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tmr_q <= TW'(0);
      t_q   <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      t_q   <= t_d;
    end
  end

  assign T = t_q;

endmodule

// File: tb/tb_lab084_xt_gen.sv
// Testbench for lab084_xt_gen with default parameters. Directed steps cover
// reset, clean edges, glitches, dwell pulses, abort/re-entry and reset
// mid-operation; a randomized phase follows. Every edge is compared with a
// behavioural model: X flips once the two-cycle-delayed switch level has
// disagreed with it for DEB consecutive edges; T is high when the length of
// the current run of edges sampled with Q==01 is a non-zero multiple of DWELL.
module tb_lab084_xt_gen;

  localparam int DEB   = 4;
  localparam int DWELL = 8;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       sw_in   = 1'b0;
  logic [1:0] q       = 2'b00;
  logic       X;
  logic       T;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic sw_hist[$];
  logic m_x     = 1'b0;
  logic m_t     = 1'b0;
  int   streak  = 0;
  int   run_len = 0;

  always #5 clock = ~clock;

  lab084_xt_gen #(
    .DEB_CYCLES(DEB),
    .DWELL     (DWELL)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .sw_in  (sw_in),
    .Q1     (q[1]),
    .Q0     (q[0]),
    .X      (X),
    .T      (T)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs sampled there.
  task automatic model_edge();
    logic s2;
    if (!reset_n) begin
      sw_hist = '{1'b0, 1'b0};
      m_x     = 1'b0;
      m_t     = 1'b0;
      streak  = 0;
      run_len = 0;
    end else begin
      // sw_hist holds {s2, s1}: the switch level sampled two and one edges ago
      s2 = sw_hist[0];
      if (s2 != m_x) begin
        streak++;
        if (streak == DEB) begin
          m_x    = s2;
          streak = 0;
        end
      end else begin
        streak = 0;
      end
      void'(sw_hist.pop_front());
      sw_hist.push_back(sw_in);
      if (q == 2'b01) begin
        run_len++;
        m_t = ((run_len % DWELL) == 0);
      end else begin
        run_len = 0;
        m_t     = 1'b0;
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      #1;
      check("X_model", X, m_x);
      check("T_model", T, m_t);
    end
  endtask

  initial begin
    sw_hist = '{1'b0, 1'b0};

    // Reset held for two edges with sw_in=1 and Q=01
    reset_n = 1'b0; sw_in = 1'b1; q = 2'b01;
    tick(1);
    check("rst_X_e1", X, 1'b0);
    check("rst_T_e1", T, 1'b0);
    tick(1);
    check("rst_X_e2", X, 1'b0);
    check("rst_T_e2", T, 1'b0);
    reset_n = 1'b1; sw_in = 1'b0; q = 2'b00;
    tick(10);

    // Clean edge 0->1 then 1->0
    sw_in = 1'b1;
    tick(5);
    check("clean_rise_e5", X, 1'b0);
    tick(1);
    check("clean_rise_e6", X, 1'b1);
    tick(4);
    sw_in = 1'b0;
    tick(5);
    check("clean_fall_e5", X, 1'b1);
    tick(1);
    check("clean_fall_e6", X, 1'b0);

    // Glitch of 3 cycles is filtered; 5 cycles gets through
    sw_in = 1'b1;
    tick(3);
    sw_in = 1'b0;
    tick(10);
    check("glitch3_X", X, 1'b0);
    sw_in = 1'b1;
    tick(5);
    sw_in = 1'b0;
    tick(1);
    check("pulse5_X", X, 1'b1);
    tick(10);
    check("pulse5_back_X", X, 1'b0);

    // Dwell with wrap
    q = 2'b01;
    tick(7);
    check("dwell_e7", T, 1'b0);
    tick(1);
    check("dwell_e8", T, 1'b1);
    tick(1);
    check("dwell_e9", T, 1'b0);
    tick(6);
    check("dwell_e15", T, 1'b0);
    tick(1);
    check("dwell_e16", T, 1'b1);
    q = 2'b10;
    tick(1);
    check("dwell_leave", T, 1'b0);

    // Abort after 5 cycles, re-entry restarts from 0
    q = 2'b01;
    tick(5);
    q = 2'b10;
    tick(2);
    q = 2'b01;
    tick(7);
    check("reentry_e7", T, 1'b0);
    tick(1);
    check("reentry_e8", T, 1'b1);
    q = 2'b00;
    tick(2);

    // Reset one cycle before a pulse is due and mid-debounce
    q = 2'b01;
    tick(3);
    sw_in = 1'b1;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    check("midrst_T", T, 1'b0);
    check("midrst_X", X, 1'b0);
    reset_n = 1'b1;
    tick(5);
    check("post_rst_X_e5", X, 1'b0);
    tick(1);
    check("post_rst_X_e6", X, 1'b1);
    tick(1);
    check("post_rst_T_e7", T, 1'b0);
    tick(1);
    check("post_rst_T_e8", T, 1'b1);
    q = 2'b00;
    tick(3);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        sw_in = ~sw_in;
      end
      if ($urandom_range(0, 15) == 0) begin
        q = 2'($urandom_range(0, 3));
      end
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
